// File: rtl/midi_in_framer.sv
// midi_in_framer: turns raw UART MIDI bytes into the decoder's framed stream
//   (registered status, data-byte index, data byte, byteready strobe held HOLD_CYCLES).
// Latency: rx_valid while idle -> byteready and outputs valid on the next clock.
// Backpressure: none upstream; a one-entry pending buffer absorbs a byte while a strobe
//   or its frozen gap is in progress, and a further byte is dropped with overrun_err set.
// Ports: CLOCK_25 clock, iRST async active-high reset, rx_valid/rx_byte from the UART,
//   byteready/cur_status/midi_bytes/databyte to the decoder, sticky overrun_err/orphan_err.
// Build option MIDI_CHANNEL_FILTER_EN: adds channel_sel[3:0]; channel messages whose
//   channel differs are swallowed silently. Without it all channels pass.
module midi_in_framer #(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 4
) (
    input  logic       CLOCK_25,
    input  logic       iRST,
`ifdef MIDI_CHANNEL_FILTER_EN
    input  logic [3:0] channel_sel,
`endif
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       byteready,
    output logic [7:0] cur_status,
    output logic [7:0] midi_bytes,
    output logic [7:0] databyte,
    output logic       overrun_err,
    output logic       orphan_err
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    typedef struct packed {
        logic [7:0] status;
        logic [7:0] count;
        logic [7:0] data;
    } frame_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;

    // Running classification state, advanced when a byte is accepted.
    logic [7:0] cls_status, cls_cnt;
    logic       cls_vld, cls_filt;
    logic [7:0] n_status, n_cnt, inc;
    logic       n_vld, n_filt;
    logic       c_emit, c_orphan, c_upd, chan_pass;
    frame_t     cls_frame, pend, load_frame;
    logic       pend_full;

    logic emit_req, gap_done, hold_done, take_direct, to_pend, overrun, upd;
    logic load_new, load_pend;

    // Data bytes that complete a system-common message.
    function automatic logic [7:0] sys_len(input logic [7:0] s);
        case (s)
            8'hF1, 8'hF3: return 8'd1;
            8'hF2:        return 8'd2;
            default:      return 8'd0;
        endcase
    endfunction

    always_comb begin
        c_emit    = 1'b0;
        c_orphan  = 1'b0;
        c_upd     = 1'b0;
        n_status  = cls_status;
        n_vld     = cls_vld;
        n_cnt     = cls_cnt;
        n_filt    = cls_filt;
        inc       = cls_cnt + 8'd1;
`ifdef MIDI_CHANNEL_FILTER_EN
        chan_pass = (rx_byte[3:0] == channel_sel);
`else
        chan_pass = 1'b1;
`endif
        if (rx_byte[7]) begin
            // Real-time bytes (F8-FF) fall through untouched.
            if (rx_byte[7:3] != 5'b11111) begin
                c_upd  = 1'b1;
                c_emit = 1'b1;
                n_cnt  = 8'h00;
                n_filt = 1'b0;
                if (rx_byte < 8'hF0) begin
                    n_status = rx_byte;
                    n_vld    = 1'b1;
                    n_filt   = !chan_pass;
                    c_emit   = chan_pass;
                end else if (rx_byte == 8'hF7) begin
                    // End of sysex keeps the reported status but ends running status.
                    n_vld = 1'b0;
                end else begin
                    n_status = rx_byte;
                    n_vld    = (rx_byte == 8'hF0) || (sys_len(rx_byte) != 8'd0);
                end
            end
        end else if (!cls_vld) begin
            c_orphan = 1'b1;
        end else if (!cls_filt) begin
            c_upd  = 1'b1;
            c_emit = 1'b1;
            case (cls_status[7:4])
                4'hC, 4'hD: n_cnt = 8'd1;
                4'hF: begin
                    if (cls_status == 8'hF0) begin
                        n_cnt = (cls_cnt == 8'hFF) ? 8'hFF : inc;
                    end else begin
                        n_cnt = inc;
                        if (inc == sys_len(cls_status)) n_vld = 1'b0;
                    end
                end
                // Two-byte channel messages: wrap FE -> 1 keeps odd/even pairing.
                default: n_cnt = (cls_cnt == 8'hFE) ? 8'd1 : inc;
            endcase
        end
        cls_frame.status = n_status;
        cls_frame.count  = n_cnt;
        cls_frame.data   = rx_byte;
    end

    assign emit_req    = rx_valid && c_emit;
    assign hold_done   = (state == PULSE) && (cnt == 16'(HOLD_CYCLES - 1));
    assign gap_done    = (state == GAP) && (cnt == 16'(GAP_CYCLES - 1));
    assign take_direct = emit_req && ((state == IDLE) || (gap_done && !pend_full));
    // At gap completion the buffered byte leaves, so a full buffer can still accept.
    assign to_pend     = emit_req && !take_direct && (!pend_full || gap_done);
    assign overrun     = emit_req && pend_full && !gap_done;
    assign upd         = rx_valid && c_upd && (!c_emit || take_direct || to_pend);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_new  = 1'b0;
        load_pend = 1'b0;
        case (state)
            IDLE: begin
                if (take_direct) begin
                    load_new  = 1'b1;
                    state_nxt = PULSE;
                    cnt_nxt   = '0;
                end
            end
            PULSE: begin
                if (hold_done) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            GAP: begin
                if (gap_done) begin
                    cnt_nxt = '0;
                    if (pend_full) begin
                        load_pend = 1'b1;
                        state_nxt = PULSE;
                    end else if (take_direct) begin
                        load_new  = 1'b1;
                        state_nxt = PULSE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        load_frame = load_pend ? pend : cls_frame;
    end

    always_ff @(posedge CLOCK_25 or posedge iRST) begin
        if (iRST) begin
            state      <= IDLE;
            cnt        <= '0;
            byteready  <= 1'b0;
            cur_status <= 8'h00;
            midi_bytes <= 8'h00;
            databyte   <= 8'h00;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            byteready <= (state_nxt == PULSE);
            if (load_new || load_pend) begin
                cur_status <= load_frame.status;
                midi_bytes <= load_frame.count;
                databyte   <= load_frame.data;
            end
        end
    end

    always_ff @(posedge CLOCK_25 or posedge iRST) begin
        if (iRST) begin
            cls_status  <= 8'h00;
            cls_cnt     <= 8'h00;
            cls_vld     <= 1'b0;
            cls_filt    <= 1'b0;
            pend        <= '0;
            pend_full   <= 1'b0;
            overrun_err <= 1'b0;
            orphan_err  <= 1'b0;
        end else begin
            if (upd) begin
                cls_status <= n_status;
                cls_cnt    <= n_cnt;
                cls_vld    <= n_vld;
                cls_filt   <= n_filt;
            end
            if (to_pend) begin
                pend      <= cls_frame;
                pend_full <= 1'b1;
            end else if (load_pend) begin
                pend_full <= 1'b0;
            end
            if (overrun) overrun_err <= 1'b1;
            if (rx_valid && c_orphan) orphan_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_midi_in_framer.sv
// tb_midi_in_framer: directed bench for midi_in_framer.
// A negedge monitor records every strobe (status,count,data), its high time, the low time
// before it, and any output change that is not accompanied by a rising byteready.
module tb_midi_in_framer;
    logic       CLOCK_25 = 1'b0;
    logic       iRST;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       byteready;
    logic [7:0] cur_status, midi_bytes, databyte;
    logic       overrun_err, orphan_err;
`ifdef MIDI_CHANNEL_FILTER_EN
    logic [3:0] channel_sel;
`endif

    always #20 CLOCK_25 = ~CLOCK_25;

    midi_in_framer #(.HOLD_CYCLES(2), .GAP_CYCLES(4)) dut (
        .CLOCK_25   (CLOCK_25),
        .iRST       (iRST),
`ifdef MIDI_CHANNEL_FILTER_EN
        .channel_sel(channel_sel),
`endif
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .byteready  (byteready),
        .cur_status (cur_status),
        .midi_bytes (midi_bytes),
        .databyte   (databyte),
        .overrun_err(overrun_err),
        .orphan_err (orphan_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] frames[$];
    int          holds[$];
    int          gaps[$];
    int          hi_run = 0, lo_run = 0, freeze_viol = 0;
    logic        prev_br = 1'b0, prev_rst = 1'b1;
    logic [23:0] prev_out = '0;

    always @(negedge CLOCK_25) begin
        if (iRST) begin
            hi_run   = 0;
            lo_run   = 0;
            prev_br  = 1'b0;
            prev_rst = 1'b1;
        end else begin
            if (byteready && !prev_br) begin
                frames.push_back({cur_status, midi_bytes, databyte});
                gaps.push_back(lo_run);
                hi_run = 0;
            end else if (!prev_rst && ({cur_status, midi_bytes, databyte} != prev_out)) begin
                freeze_viol++;
            end
            if (!byteready && prev_br) begin
                holds.push_back(hi_run);
                lo_run = 0;
            end
            if (byteready) hi_run++;
            else lo_run++;
            prev_br  = byteready;
            prev_rst = 1'b0;
        end
        prev_out = {cur_status, midi_bytes, databyte};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input int idx,
                             input logic [7:0] s, input logic [7:0] c, input logic [7:0] d);
        logic [23:0] obs;
        obs = (idx < frames.size()) ? frames[idx] : 24'hxxxxxx;
        chk(tag, {8'h00, obs}, {8'h00, s, c, d});
    endtask

    task automatic clear_log();
        frames.delete();
        holds.delete();
        gaps.delete();
    endtask

    task automatic do_reset();
        @(negedge CLOCK_25); #1;
        iRST = 1'b1;
        repeat (2) @(negedge CLOCK_25);
        #1 iRST = 1'b0;
        clear_log();
    endtask

    task automatic send(input logic [7:0] b, input int idle);
        @(negedge CLOCK_25);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge CLOCK_25);
        rx_valid = 1'b0;
        repeat (idle) @(negedge CLOCK_25);
        #1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames.size() < n && k < budget) begin
            @(negedge CLOCK_25); #1;
            k++;
        end
        chk("strobe_count_reached", frames.size(), n);
    endtask

    initial begin
        iRST     = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
`ifdef MIDI_CHANNEL_FILTER_EN
        channel_sel = 4'd0;
`endif
        repeat (3) @(negedge CLOCK_25); #1;
        chk("rst_byteready", byteready, 0);
        chk("rst_cur_status", cur_status, 8'h00);
        chk("rst_midi_bytes", midi_bytes, 8'h00);
        chk("rst_databyte", databyte, 8'h00);
        chk("rst_overrun", overrun_err, 0);
        chk("rst_orphan", orphan_err, 0);
        iRST = 1'b0;
        clear_log();

        // Note on, spaced: one-cycle latency, then three frames held two cycles each.
        @(negedge CLOCK_25);
        rx_valid = 1'b1;
        rx_byte  = 8'h90;
        @(negedge CLOCK_25);
        rx_valid = 1'b0;
        #1;
        chk("latency_byteready", byteready, 1);
        chk("latency_outputs", {cur_status, midi_bytes, databyte}, 24'h900090);
        repeat (20) @(negedge CLOCK_25);
        send(8'h3C, 20);
        send(8'h64, 20);
        chk_frame("note_status", 0, 8'h90, 8'h00, 8'h90);
        chk_frame("note_data1", 1, 8'h90, 8'h01, 8'h3C);
        chk_frame("note_data2", 2, 8'h90, 8'h02, 8'h64);
        chk("hold_count", holds.size(), 3);
        chk("hold0", holds[0], 2);
        chk("hold2", holds[2], 2);

        // Running status continues the counter.
        send(8'h40, 20);
        send(8'h50, 20);
        chk_frame("running_3", 3, 8'h90, 8'h03, 8'h40);
        chk_frame("running_4", 4, 8'h90, 8'h04, 8'h50);

        // Real-time byte in the middle of a message is invisible.
        send(8'h90, 20);
        send(8'h3C, 20);
        send(8'hF8, 20);
        send(8'h64, 20);
        chk("realtime_no_strobe", frames.size(), 8);
        chk_frame("realtime_after", 7, 8'h90, 8'h02, 8'h64);

        // Reset in the middle of a strobe: byteready drops at once, status forgotten.
        @(negedge CLOCK_25);
        rx_valid = 1'b1;
        rx_byte  = 8'h90;
        @(negedge CLOCK_25);
        rx_valid = 1'b0;
        #5 iRST = 1'b1;
        #1;
        chk("async_rst_byteready", byteready, 0);
        chk("async_rst_status", cur_status, 8'h00);
        repeat (2) @(negedge CLOCK_25);
        #1 iRST = 1'b0;
        clear_log();
        send(8'h3C, 20);
        chk("orphan_no_strobe", frames.size(), 0);
        chk("orphan_flag", orphan_err, 1);

        // Sysex counting, F7 keeps F0 as reported status.
        send(8'hF0, 12);
        send(8'h7E, 12);
        send(8'h01, 12);
        send(8'h02, 12);
        send(8'h03, 12);
        send(8'hF7, 12);
        chk_frame("sysex_start", 0, 8'hF0, 8'h00, 8'hF0);
        chk_frame("sysex_d1", 1, 8'hF0, 8'h01, 8'h7E);
        chk_frame("sysex_d4", 4, 8'hF0, 8'h04, 8'h03);
        chk_frame("sysex_end", 5, 8'hF0, 8'h00, 8'hF7);

        // Song position: two data bytes, then running status is cancelled.
        send(8'hF2, 12);
        send(8'h01, 12);
        send(8'h02, 12);
        send(8'h05, 12);
        chk_frame("songpos_d2", 8, 8'hF2, 8'h02, 8'h02);
        chk("syscommon_cancel", frames.size(), 9);

        // Program change: every data byte is index 1.
        send(8'hC5, 12);
        send(8'h10, 12);
        send(8'h11, 12);
        chk_frame("progchg_d1", 10, 8'hC5, 8'h01, 8'h10);
        chk_frame("progchg_d2", 11, 8'hC5, 8'h01, 8'h11);

        // Long running-status stream: index FE is followed by 1.
        clear_log();
        send(8'h80, 8);
        for (int k = 1; k <= 255; k++) begin
            logic [7:0] v;
            v = k[7:0] & 8'h7F;
            send(v, 8);
        end
        wait_frames(256, 40);
        chk_frame("wrap_fe", 254, 8'h80, 8'hFE, 8'h7E);
        chk_frame("wrap_one", 255, 8'h80, 8'h01, 8'h7F);

        // Back-to-back bytes: second is buffered; a third enters the buffer during the
        // second strobe, and a fourth one cycle later overflows it.
        do_reset();
        @(negedge CLOCK_25);
        rx_valid = 1'b1;
        rx_byte  = 8'hB0;
        @(negedge CLOCK_25);
        rx_byte  = 8'h7B;
        @(negedge CLOCK_25);
        rx_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLOCK_25);
            if (byteready === 1'b1 && databyte === 8'h7B) break;
        end
        chk("b2b_no_overrun", overrun_err, 0);
        rx_valid = 1'b1;
        rx_byte  = 8'h00;
        @(negedge CLOCK_25);
        rx_byte  = 8'h01;
        @(negedge CLOCK_25);
        rx_valid = 1'b0;
        #1;
        wait_frames(3, 40);
        repeat (30) @(negedge CLOCK_25);
        #1;
        chk("b2b_fourth_lost", frames.size(), 3);
        chk("b2b_overrun", overrun_err, 1);
        chk_frame("b2b_0", 0, 8'hB0, 8'h00, 8'hB0);
        chk_frame("b2b_1", 1, 8'hB0, 8'h01, 8'h7B);
        chk_frame("b2b_2", 2, 8'hB0, 8'h02, 8'h00);
        chk("b2b_gap1", gaps[1], 4);
        chk("b2b_gap2", gaps[2], 4);
        chk("b2b_hold1", holds[1], 2);

        // Channel handling: two note-ons on channels 0 and 1.
        do_reset();
`ifdef MIDI_CHANNEL_FILTER_EN
        channel_sel = 4'd1;
`endif
        send(8'h90, 12);
        send(8'h3C, 12);
        send(8'h64, 12);
        send(8'h91, 12);
        send(8'h3C, 12);
        send(8'h64, 12);
`ifdef MIDI_CHANNEL_FILTER_EN
        chk("filter_count", frames.size(), 3);
        chk_frame("filter_0", 0, 8'h91, 8'h00, 8'h91);
        chk_frame("filter_2", 2, 8'h91, 8'h02, 8'h64);
        chk("filter_no_orphan", orphan_err, 0);
`else
        chk("omni_count", frames.size(), 6);
        chk_frame("omni_2", 2, 8'h90, 8'h02, 8'h64);
        chk_frame("omni_3", 3, 8'h91, 8'h00, 8'h91);
        chk_frame("omni_5", 5, 8'h91, 8'h02, 8'h64);
`endif

        chk("outputs_frozen_between_strobes", freeze_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
